fifo_read_sched: RTL

//  Read scheduler for the NV (channel A) and MTI (channel B) sample FIFOs.

---
 rtl/fifo_read_sched.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/fifo_read_sched.sv
// Read scheduler merging the NV (A) and MTI (B) sample FIFOs into one valid/ready host stream.
// Optional FIFO_READ_SCHED_STATS_EN adds per-channel full-while-waiting counters (ovf_cnt_a/ovf_cnt_b).
module fifo_read_sched #(
    parameter int BURST = 8,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [1:0]    chan_mask,
    input  logic          abort,
    input  logic [2:0]    ffa_rdstate,
    input  logic [2:0]    ffb_rdstate,
    input  logic [DW-1:0] ffa_rddata,
    input  logic [DW-1:0] ffb_rddata,
    output logic          ffa_rden,
    output logic          ffb_rden,
    output logic [DW-1:0] out_data,
    output logic          out_src,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy
`ifdef FIFO_READ_SCHED_STATS_EN
    ,
    output logic [15:0]   ovf_cnt_a,
    output logic [15:0]   ovf_cnt_b
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        PRESENT = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(BURST - 1);

    state_t        state_r;
    logic          sel_r;
    logic          rr_r;
    logic [7:0]    cnt_r;
    logic          rden_a_r;
    logic          rden_b_r;
    logic [DW-1:0] data_r;
    logic          src_r;
    logic          last_r;
    logic          valid_r;
    logic          busy_r;

    logic          elig_a_s;
    logic          elig_b_s;
    logic          full_a_s;
    logic          full_b_s;
    logic          grant_ok_s;
    logic          grant_ch_s;
    logic          sel_empty_s;
    logic [DW-1:0] sel_data_s;
    logic          unused_af_s;

    // Almost-full is reported by the FIFOs but plays no part in scheduling.
    assign unused_af_s = ffa_rdstate[1] ^ ffb_rdstate[1];

    // Grant selection and selected-channel read-port mux.
    always_comb begin
        elig_a_s    = enable & chan_mask[0] & ~ffa_rdstate[0];
        elig_b_s    = enable & chan_mask[1] & ~ffb_rdstate[0];
        full_a_s    = elig_a_s & ffa_rdstate[2];
        full_b_s    = elig_b_s & ffb_rdstate[2];
        grant_ok_s  = elig_a_s | elig_b_s;
        grant_ch_s  = 1'b0;
        sel_empty_s = 1'b0;
        sel_data_s  = {DW{1'b0}};
        // A lone full channel pre-empts; otherwise rr wins if it can be served.
        if (full_a_s != full_b_s) begin
            grant_ch_s = full_b_s;
        end else if (rr_r == 1'b0) begin
            grant_ch_s = ~elig_a_s;
        end else begin
            grant_ch_s = elig_b_s;
        end
        if (sel_r == 1'b1) begin
            sel_empty_s = ffb_rdstate[0];
            sel_data_s  = ffb_rddata;
        end else begin
            sel_empty_s = ffa_rdstate[0];
            sel_data_s  = ffa_rddata;
        end
    end

    // Scheduler FSM with registered strobes and host-side outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= IDLE;
            sel_r    <= 1'b0;
            rr_r     <= 1'b0;
            cnt_r    <= 8'd0;
            rden_a_r <= 1'b0;
            rden_b_r <= 1'b0;
            data_r   <= {DW{1'b0}};
            src_r    <= 1'b0;
            last_r   <= 1'b0;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else if (abort) begin
            state_r  <= IDLE;
            rr_r     <= ~sel_r;
            cnt_r    <= 8'd0;
            rden_a_r <= 1'b0;
            rden_b_r <= 1'b0;
            last_r   <= 1'b0;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_ok_s) begin
                        sel_r    <= grant_ch_s;
                        cnt_r    <= 8'd0;
                        rden_a_r <= ~grant_ch_s;
                        rden_b_r <= grant_ch_s;
                        busy_r   <= 1'b1;
                        state_r  <= ISSUE;
                    end else begin
                        busy_r   <= 1'b0;
                    end
                end
                ISSUE: begin
                    rden_a_r <= 1'b0;
                    rden_b_r <= 1'b0;
                    state_r  <= CAPTURE;
                end
                CAPTURE: begin
                    // Empty is checked after the pop, so a drained FIFO ends the burst without a further read.
                    data_r  <= sel_data_s;
                    src_r   <= sel_r;
                    last_r  <= (cnt_r == CNT_LAST) | sel_empty_s;
                    valid_r <= 1'b1;
                    state_r <= PRESENT;
                end
                PRESENT: begin
                    if (out_ready) begin
                        valid_r <= 1'b0;
                        if (last_r) begin
                            cnt_r   <= 8'd0;
                            rr_r    <= ~sel_r;
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            cnt_r    <= cnt_r + 8'd1;
                            rden_a_r <= ~sel_r;
                            rden_b_r <= sel_r;
                            state_r  <= ISSUE;
                        end
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    rden_a_r <= 1'b0;
                    rden_b_r <= 1'b0;
                    valid_r  <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    assign ffa_rden  = rden_a_r;
    assign ffb_rden  = rden_b_r;
    assign out_data  = data_r;
    assign out_src   = src_r;
    assign out_last  = last_r;
    assign out_valid = valid_r;
    assign busy      = busy_r;

`ifdef FIFO_READ_SCHED_STATS_EN
    logic [15:0] ovf_a_r;
    logic [15:0] ovf_b_r;

    // Saturating count of clocks a channel sits full while the other one is being served.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf_a_r <= 16'd0;
            ovf_b_r <= 16'd0;
        end else begin
            if ((state_r != IDLE) && ffa_rdstate[2] && (sel_r != 1'b0) && (ovf_a_r != 16'hFFFF)) begin
                ovf_a_r <= ovf_a_r + 16'd1;
            end
            if ((state_r != IDLE) && ffb_rdstate[2] && (sel_r != 1'b1) && (ovf_b_r != 16'hFFFF)) begin
                ovf_b_r <= ovf_b_r + 16'd1;
            end
        end
    end

    assign ovf_cnt_a = ovf_a_r;
    assign ovf_cnt_b = ovf_b_r;
`endif

endmodule
